// File: rtl/uart_fifo.sv
// Byte FIFOs between a CPU valid/ready stream and the pulse-style uart engine.
// Define UART_FIFO_OVERFLOW_EN to build the sticky rx_overflow flag.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_tx_valid,
  input  logic [7:0]    cpu_tx_data,
  output logic          cpu_tx_ready,
  output logic          cpu_rx_valid,
  output logic [7:0]    cpu_rx_data,
  input  logic          cpu_rx_ready,
  output logic [AW:0]   tx_count,
  output logic [AW:0]   rx_count,
  output logic          rx_overflow,
  input  logic          rx_overflow_clr,
  output logic          uart_tx_valid,
  output logic [7:0]    uart_tx_data,
  input  logic          uart_tx_complete,
  input  logic          uart_rx_complete,
  input  logic [7:0]    uart_rx_data
);

  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  tx_state_e     tx_st_q, tx_st_d;
  logic [7:0]    tx_dat_q, tx_dat_d;
  logic          tx_push, tx_pop;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;
  logic          rx_push, rx_pop, rx_full, rx_drop;

  assign cpu_tx_ready  = tx_cnt_q != FULL;
  assign tx_push       = cpu_tx_valid && cpu_tx_ready;
  assign tx_count      = tx_cnt_q;
  assign uart_tx_valid = tx_st_q == TX_BUSY;
  assign uart_tx_data  = tx_dat_q;

  // Holding register stays put for the whole frame; reload only on pop.
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_dat_d = tx_dat_q;
    tx_pop   = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: begin
        if (tx_cnt_q != '0) begin
          tx_pop  = 1'b1;
          tx_st_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (uart_tx_complete) begin
          if (tx_cnt_q != '0) tx_pop = 1'b1;
          else tx_st_d = TX_IDLE;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
    if (tx_pop) tx_dat_d = tx_mem_q[tx_rd_q];
  end

  always_comb begin
    tx_wr_d  = tx_wr_q + AW'(tx_push);
    tx_rd_d  = tx_rd_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push)
                        - (AW+1)'(tx_pop);
  end

  assign cpu_rx_valid = rx_cnt_q != '0;
  assign cpu_rx_data  = rx_mem_q[rx_rd_q];
  assign rx_count     = rx_cnt_q;
  assign rx_full      = rx_cnt_q == FULL;
  assign rx_pop       = cpu_rx_valid && cpu_rx_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept.
  assign rx_push      = uart_rx_complete && (!rx_full || rx_pop);
  assign rx_drop      = uart_rx_complete && rx_full && !rx_pop;

  always_comb begin
    rx_wr_d  = rx_wr_q + AW'(rx_push);
    rx_rd_d  = rx_rd_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push)
                        - (AW+1)'(rx_pop);
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= cpu_tx_data;
    if (rx_push) rx_mem_q[rx_wr_q] <= uart_rx_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      tx_st_q  <= TX_IDLE;
      tx_dat_q <= 8'h00;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      tx_st_q  <= tx_st_d;
      tx_dat_q <= tx_dat_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

`ifdef UART_FIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (rx_overflow_clr) ovf_d = 1'b0;
    if (rx_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end

  assign rx_overflow = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf  = rx_overflow_clr ^ rx_drop;
  assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: queued expectations, decoupled monitors.
module tb_uart_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int FRAME = 500;
`ifdef UART_FIFO_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_tx_valid = 1'b0;
  logic [7:0]    cpu_tx_data = 8'h00;
  logic          cpu_tx_ready;
  logic          cpu_rx_valid;
  logic [7:0]    cpu_rx_data;
  logic          cpu_rx_ready = 1'b0;
  logic [AW:0]   tx_count;
  logic [AW:0]   rx_count;
  logic          rx_overflow;
  logic          rx_overflow_clr = 1'b0;
  logic          uart_tx_valid;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_complete;
  logic          uart_rx_complete = 1'b0;
  logic [7:0]    uart_rx_data = 8'h00;

  logic model_cpl = 1'b0;
  logic spur_cpl = 1'b0;
  logic uart_stall = 1'b0;
  assign uart_tx_complete = model_cpl | spur_cpl;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic [7:0] tx_e, rx_e;
  logic prev_v = 1'b0;
  logic prev_c = 1'b0;

  always #5 clock = ~clock;

  uart_fifo #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .cpu_tx_valid(cpu_tx_valid),
    .cpu_tx_data(cpu_tx_data),
    .cpu_tx_ready(cpu_tx_ready),
    .cpu_rx_valid(cpu_rx_valid),
    .cpu_rx_data(cpu_rx_data),
    .cpu_rx_ready(cpu_rx_ready),
    .tx_count(tx_count),
    .rx_count(rx_count),
    .rx_overflow(rx_overflow),
    .rx_overflow_clr(rx_overflow_clr),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_data(uart_tx_data),
    .uart_tx_complete(uart_tx_complete),
    .uart_rx_complete(uart_rx_complete),
    .uart_rx_data(uart_rx_data)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // uart model: completes each frame FRAME cycles after valid is seen
  initial begin
    int t;
    t = 0;
    forever begin
      @(posedge clock);
      #1;
      model_cpl = 1'b0;
      if (uart_tx_valid && !uart_stall) begin
        t++;
        if (t == FRAME) begin
          model_cpl = 1'b1;
          t = 0;
        end
      end else begin
        t = 0;
      end
    end
  end

  // TX monitor: a frame starts when valid rises or right after a complete
  always @(negedge clock) begin
    if (reset_n && uart_tx_valid && (!prev_v || prev_c)) begin
      checks++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("FAIL tx_frame got %02h expected none", uart_tx_data);
      end else begin
        tx_e = tx_exp.pop_front();
        if (uart_tx_data !== tx_e) begin
          errors++;
          $display("FAIL tx_frame got %02h expected %02h",
                   uart_tx_data, tx_e);
        end
      end
    end
    prev_v = uart_tx_valid;
    prev_c = uart_tx_complete;
  end

  // RX monitor: compare the head whenever the CPU consumes it
  always @(negedge clock) begin
    if (reset_n && cpu_rx_valid && cpu_rx_ready) begin
      checks++;
      if (rx_exp.size() == 0) begin
        errors++;
        $display("FAIL rx_pop got %02h expected none", cpu_rx_data);
      end else begin
        rx_e = rx_exp.pop_front();
        if (cpu_rx_data !== rx_e) begin
          errors++;
          $display("FAIL rx_pop got %02h expected %02h",
                   cpu_rx_data, rx_e);
        end
      end
    end
  end

  initial begin
    int n;
    // reset
    repeat (3) tick();
    chk("rst_txv", 32'(uart_tx_valid), 32'd0);
    chk("rst_rxv", 32'(cpu_rx_valid), 32'd0);
    chk("rst_txr", 32'(cpu_tx_ready), 32'd1);
    reset_n = 1'b1;
    tick();
    chk("rel_txc", 32'(tx_count), 32'd0);
    chk("rel_rxc", 32'(rx_count), 32'd0);
    chk("rel_ovf", 32'(rx_overflow), 32'd0);
    chk("rel_dat", 32'(uart_tx_data), 32'h00);

    // spurious complete while idle
    spur_cpl = 1'b1;
    tick();
    spur_cpl = 1'b0;
    tick();
    chk("spur_txc", 32'(tx_count), 32'd0);
    chk("spur_txv", 32'(uart_tx_valid), 32'd0);

    // burst TX
    cpu_tx_valid = 1'b1;
    cpu_tx_data = 8'h41; tx_exp.push_back(8'h41);
    tick();
    cpu_tx_data = 8'h42; tx_exp.push_back(8'h42);
    tick();
    chk("lat_txv", 32'(uart_tx_valid), 32'd1);
    cpu_tx_data = 8'h43; tx_exp.push_back(8'h43);
    tick();
    cpu_tx_valid = 1'b0;
    chk("burst_peak", 32'(tx_count), 32'd2);
    n = 0;
    for (int i = 0; i < 2000 && n < 3; i++) begin
      @(negedge clock);
      if (uart_tx_complete) n++;
    end
    chk("burst_cpls", 32'(n), 32'd3);
    chk("burst_hold", 32'(uart_tx_valid), 32'd1);
    @(negedge clock);
    chk("burst_drop", 32'(uart_tx_valid), 32'd0);
    chk("burst_left", 32'(tx_exp.size()), 32'd0);

    // TX full with the uart stalled
    tick();
    uart_stall = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cpu_tx_valid = 1'b1;
      cpu_tx_data = 8'(8'h60 + i);
      chk("full_rdy", 32'(cpu_tx_ready), (i < 17) ? 32'd1 : 32'd0);
      if (i < 17) tx_exp.push_back(cpu_tx_data);
      tick();
    end
    cpu_tx_valid = 1'b0;
    chk("full_txc", 32'(tx_count), 32'd16);
    chk("full_rdy0", 32'(cpu_tx_ready), 32'd0);
    chk("full_txv", 32'(uart_tx_valid), 32'd1);

    // asynchronous reset mid-frame
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_txc", 32'(tx_count), 32'd0);
    chk("arst_rdy", 32'(cpu_tx_ready), 32'd1);
    chk("arst_txv", 32'(uart_tx_valid), 32'd0);
    tx_exp.delete();
    tick();
    reset_n = 1'b1;
    uart_stall = 1'b0;
    tick();

    // RX order and backpressure
    cpu_rx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      uart_rx_complete = 1'b1;
      uart_rx_data = 8'(8'h10 + i);
      rx_exp.push_back(uart_rx_data);
      tick();
      if (i == 0) chk("rx_lat", 32'(cpu_rx_valid), 32'd1);
    end
    uart_rx_complete = 1'b0;
    chk("rx_full", 32'(rx_count), 32'd16);
    chk("rx_noovf", 32'(rx_overflow), 32'd0);

    // overflow drop
    uart_rx_complete = 1'b1;
    uart_rx_data = 8'hAA;
    tick();
    uart_rx_complete = 1'b0;
    chk("ovf_cnt", 32'(rx_count), 32'd16);
    chk("ovf_set", 32'(rx_overflow), 32'(OVF));
    rx_overflow_clr = 1'b1;
    tick();
    rx_overflow_clr = 1'b0;
    chk("ovf_clr", 32'(rx_overflow), 32'd0);

    // full with same-cycle pop: accepted
    uart_rx_complete = 1'b1;
    uart_rx_data = 8'hAA;
    cpu_rx_ready = 1'b1;
    rx_exp.push_back(8'hAA);
    tick();
    uart_rx_complete = 1'b0;
    cpu_rx_ready = 1'b0;
    chk("pp_cnt", 32'(rx_count), 32'd16);
    chk("pp_ovf", 32'(rx_overflow), 32'd0);

    // set beats clear
    uart_rx_complete = 1'b1;
    uart_rx_data = 8'hBB;
    rx_overflow_clr = 1'b1;
    tick();
    uart_rx_complete = 1'b0;
    rx_overflow_clr = 1'b0;
    chk("setwin", 32'(rx_overflow), 32'(OVF));
    rx_overflow_clr = 1'b1;
    tick();
    rx_overflow_clr = 1'b0;
    chk("clr2", 32'(rx_overflow), 32'd0);

    // drain
    cpu_rx_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!cpu_rx_valid) break;
      tick();
    end
    cpu_rx_ready = 1'b0;
    chk("drain_cnt", 32'(rx_count), 32'd0);
    chk("drain_v", 32'(cpu_rx_valid), 32'd0);
    chk("drain_left", 32'(rx_exp.size()), 32'd0);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
